// File: rtl/rgb_to_gray_pkg.sv
// rtl/rgb_to_gray_pkg.sv - shared constants and stage sideband type for the RGB-to-luma converter
package rgb_to_gray_pkg;

    localparam int COEF_WIDTH_DEF = 8;
    localparam int COEF_R_DEF     = 77;
    localparam int COEF_G_DEF     = 150;
    localparam int COEF_B_DEF     = 29;

    localparam int CH_G = 0;
    localparam int CH_B = 1;
    localparam int CH_R = 2;

    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_USER_W = 1;
    localparam int AXIS_DEST_W = 4;
    localparam int AXIS_ID_W   = 4;
    localparam int AXIS_STRB_W = AXIS_DATA_W / 8;

    typedef struct packed {
        logic                   valid;
        logic                   last;
        logic [AXIS_USER_W-1:0] user;
        logic [AXIS_DEST_W-1:0] dest;
        logic [AXIS_ID_W-1:0]   id;
    } sideband_t;

endpackage

// File: rtl/rgb_to_grayscale_converter_if.sv
// rtl/rgb_to_grayscale_converter_if.sv - AXI4-Stream video bundle with master/slave views
interface rgb_to_grayscale_converter_if;
    import rgb_to_gray_pkg::*;

    logic [AXIS_DATA_W-1:0] tdata;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;
    logic [AXIS_USER_W-1:0] tuser;
    logic [AXIS_DEST_W-1:0] tdest;
    logic [AXIS_ID_W-1:0]   tid;
    logic [AXIS_STRB_W-1:0] tstrb;
    logic [AXIS_STRB_W-1:0] tkeep;

    modport master (
        output tdata, tvalid, tlast, tuser, tdest, tid, tstrb, tkeep,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tlast, tuser, tdest, tid, tstrb, tkeep,
        output tready
    );

endinterface

// File: rtl/px_weight_mult.sv
// rtl/px_weight_mult.sv - registered channel x coefficient product with load enable
module px_weight_mult #(
    parameter int PX_WIDTH   = 10,
    parameter int COEF_WIDTH = 8,
    parameter int COEF       = 77
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             en_i,
    input  logic [PX_WIDTH-1:0]              px_i,
    output logic [PX_WIDTH+COEF_WIDTH:0]     prod_o
);

    localparam int PROD_W = PX_WIDTH + COEF_WIDTH + 1;

    logic [PROD_W-1:0] prod_d;
    logic [PROD_W-1:0] prod_q;

    assign prod_d = PROD_W'(px_i) * PROD_W'(COEF);

    // Data is reset too so a bubble never carries X toward the output.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prod_q <= '0;
        end else if (en_i) begin
            prod_q <= prod_d;
        end
    end

    assign prod_o = prod_q;

endmodule

// File: rtl/rgb_to_grayscale_converter.sv
// rtl/rgb_to_grayscale_converter.sv - 3-stage RGB to luma stream; RGB_TO_GRAY_ROUND_EN selects round-half-up
module rgb_to_grayscale_converter
    import rgb_to_gray_pkg::*;
#(
    parameter int PX_WIDTH   = 10,
    parameter int COEF_WIDTH = COEF_WIDTH_DEF,
    parameter int COEF_R     = COEF_R_DEF,
    parameter int COEF_G     = COEF_G_DEF,
    parameter int COEF_B     = COEF_B_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    rgb_to_grayscale_converter_if.slave   video_i,
    rgb_to_grayscale_converter_if.master  video_o
);

    localparam int PROD_W = PX_WIDTH + COEF_WIDTH + 1;
    localparam int SUM_W  = PROD_W + 2;
    localparam logic [SUM_W-1:0] Y_MAX = SUM_W'((1 << PX_WIDTH) - 1);
`ifdef RGB_TO_GRAY_ROUND_EN
    localparam logic [SUM_W-1:0] ROUND_ADD = SUM_W'(1 << (COEF_WIDTH - 1));
`else
    localparam logic [SUM_W-1:0] ROUND_ADD = '0;
`endif

    logic adv;

    logic [PROD_W-1:0] prod_r;
    logic [PROD_W-1:0] prod_g;
    logic [PROD_W-1:0] prod_b;

    sideband_t sb_in_d;
    sideband_t sb_s1_q;
    sideband_t sb_s2_q;
    sideband_t sb_s3_q;

    logic [SUM_W-1:0]    sum_d;
    logic [SUM_W-1:0]    sum_q;
    logic [SUM_W-1:0]    shifted;
    logic [PX_WIDTH-1:0] y_d;
    logic [PX_WIDTH-1:0] y_q;
    logic                strb_q;

    logic unused_in_bits;
    assign unused_in_bits = ^{video_i.tdata[AXIS_DATA_W-1:3*PX_WIDTH], video_i.tstrb, video_i.tkeep};

    // One global enable: the whole pipe moves together, bubbles included.
    assign adv            = !sb_s3_q.valid || video_o.tready;
    assign video_i.tready = adv;

    px_weight_mult #(.PX_WIDTH(PX_WIDTH), .COEF_WIDTH(COEF_WIDTH), .COEF(COEF_R)) u_mult_r (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (adv),
        .px_i    (video_i.tdata[CH_R*PX_WIDTH +: PX_WIDTH]),
        .prod_o  (prod_r)
    );

    px_weight_mult #(.PX_WIDTH(PX_WIDTH), .COEF_WIDTH(COEF_WIDTH), .COEF(COEF_G)) u_mult_g (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (adv),
        .px_i    (video_i.tdata[CH_G*PX_WIDTH +: PX_WIDTH]),
        .prod_o  (prod_g)
    );

    px_weight_mult #(.PX_WIDTH(PX_WIDTH), .COEF_WIDTH(COEF_WIDTH), .COEF(COEF_B)) u_mult_b (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (adv),
        .px_i    (video_i.tdata[CH_B*PX_WIDTH +: PX_WIDTH]),
        .prod_o  (prod_b)
    );

    always_comb begin
        sb_in_d       = '0;
        sb_in_d.valid = video_i.tvalid;
        sb_in_d.last  = video_i.tlast;
        sb_in_d.user  = video_i.tuser;
        sb_in_d.dest  = video_i.tdest;
        sb_in_d.id    = video_i.tid;
    end

    assign sum_d   = SUM_W'(prod_r) + SUM_W'(prod_g) + SUM_W'(prod_b);
    assign shifted = (sum_q + ROUND_ADD) >> COEF_WIDTH;

    // Saturation only matters when the coefficients sum above unity.
    always_comb begin
        y_d = shifted[PX_WIDTH-1:0];
        if (shifted > Y_MAX) begin
            y_d = Y_MAX[PX_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sb_s1_q <= '0;
            sb_s2_q <= '0;
            sb_s3_q <= '0;
            sum_q   <= '0;
            y_q     <= '0;
            strb_q  <= 1'b0;
        end else begin
            strb_q <= 1'b1;
            if (adv) begin
                sb_s1_q <= sb_in_d;
                sb_s2_q <= sb_s1_q;
                sb_s3_q <= sb_s2_q;
                sum_q   <= sum_d;
                y_q     <= y_d;
            end
        end
    end

    assign video_o.tdata  = AXIS_DATA_W'(y_q);
    assign video_o.tvalid = sb_s3_q.valid;
    assign video_o.tlast  = sb_s3_q.last;
    assign video_o.tuser  = sb_s3_q.user;
    assign video_o.tdest  = sb_s3_q.dest;
    assign video_o.tid    = sb_s3_q.id;
    assign video_o.tstrb  = {AXIS_STRB_W{strb_q}};
    assign video_o.tkeep  = {AXIS_STRB_W{strb_q}};

endmodule
